// File: rtl/m65c02_pkg.sv
// Shared encodings for the m65c02 memory bus: microcode I/O operations,
// decoded address regions and bus-cycle controller states.
package m65c02_pkg;

    typedef enum logic [1:0] {
        IO_NONE = 2'b00,
        IO_WR   = 2'b01,
        IO_RD   = 2'b10,
        IO_IF   = 2'b11
    } io_op_e;

    typedef enum logic [1:0] {
        RGN_RAM = 2'd0,
        RGN_ROM = 2'd1,
        RGN_IO  = 2'd2
    } region_e;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_WS   = 2'd1,
        BUS_XW   = 2'd2
    } bus_state_e;

endpackage

// File: rtl/m65c02_rgn_decode.sv
// Combinational address-to-region decode plus the wait-state count of that region.
module m65c02_rgn_decode
    import m65c02_pkg::*;
#(
    parameter int unsigned pWait_RAM = 0,
    parameter int unsigned pWait_ROM = 1,
    parameter int unsigned pWait_IO  = 3,
    parameter logic [7:0]  pIO_Page  = 8'hFE
) (
    input  logic [15:0] Addr_i,
    output region_e     Rgn_o,
    output logic [2:0]  Wait_o
);

    // The IO page is tested first so it wins even when it lies inside the ROM window.
    always_comb begin
        Rgn_o  = RGN_RAM;
        Wait_o = 3'(pWait_RAM);
        if (Addr_i[15:8] == pIO_Page) begin
            Rgn_o  = RGN_IO;
            Wait_o = 3'(pWait_IO);
        end else if (Addr_i[15:12] == 4'hF) begin
            Rgn_o  = RGN_ROM;
            Wait_o = 3'(pWait_ROM);
        end
    end

endmodule

// File: rtl/m65c02_bus_ctrl.sv
// m65c02 memory bus cycle controller: decodes the target region, drives chip
// enables and strobes, inserts internal/external wait states and returns Rdy.
module m65c02_bus_ctrl
    import m65c02_pkg::*;
#(
    parameter int unsigned pWait_RAM = 0,
    parameter int unsigned pWait_ROM = 1,
    parameter int unsigned pWait_IO  = 3,
    parameter logic [7:0]  pIO_Page  = 8'hFE
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] AO,
    input  logic [1:0]  IO_Op,
    input  logic [7:0]  DO,
    output logic [7:0]  DI,
    output logic        Rdy,
    output logic        Sync,
    output logic [15:0] XA,
    output logic [7:0]  XDO,
    input  logic [7:0]  XDI,
    output logic        nRD,
    output logic        nWR,
    output logic        nCE_RAM,
    output logic        nCE_ROM,
    output logic        nCE_IO,
    input  logic        XWait
);

    if (pWait_RAM > 7 || pWait_ROM > 7 || pWait_IO > 7) begin : gBadWaitCfg
        $error("m65c02_bus_ctrl: wait-state parameters must be in the range 0..7");
    end

    bus_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    io_op_e      op_q, op_d;

    io_op_e      curOp;
    logic        active;
    logic [15:0] decAddr;
    region_e     rgn;
    logic [2:0]  rgnWait;

    // The first clock of a cycle decodes the live address; later clocks use the latch.
    assign decAddr = (state_q == BUS_IDLE) ? AO : addr_q;

    m65c02_rgn_decode #(
        .pWait_RAM (pWait_RAM),
        .pWait_ROM (pWait_ROM),
        .pWait_IO  (pWait_IO),
        .pIO_Page  (pIO_Page)
    ) uRgnDecode (
        .Addr_i (decAddr),
        .Rgn_o  (rgn),
        .Wait_o (rgnWait)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= BUS_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 16'h0000;
            data_q  <= 8'h00;
            op_q    <= IO_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        op_d    = op_q;
        curOp   = op_q;
        active  = 1'b1;
        Rdy     = 1'b0;
        XA      = addr_q;
        XDO     = data_q;

        case (state_q)
            BUS_IDLE: begin
                XA    = AO;
                XDO   = DO;
                curOp = io_op_e'(IO_Op);
                if (curOp == IO_NONE) begin
                    active = 1'b0;
                    Rdy    = 1'b1;
                end else if (rgnWait == 3'd0 && !XWait) begin
                    Rdy = 1'b1;
                end else begin
                    addr_d = AO;
                    data_d = DO;
                    op_d   = curOp;
                    if (rgnWait == 3'd0) begin
                        state_d = BUS_XW;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = BUS_WS;
                        cnt_d   = rgnWait - 3'd1;
                    end
                end
            end
            BUS_WS: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (!XWait) begin
                    Rdy     = 1'b1;
                    state_d = BUS_IDLE;
                end else begin
                    state_d = BUS_XW;
                end
            end
            BUS_XW: begin
                if (!XWait) begin
                    Rdy     = 1'b1;
                    state_d = BUS_IDLE;
                end
            end
            default: begin
                active  = 1'b0;
                state_d = BUS_IDLE;
            end
        endcase

        // Reset aborts any cycle in the same clock: strobes released, live bus passed through.
        if (Rst) begin
            active = 1'b0;
            Rdy    = 1'b0;
            XA     = AO;
            XDO    = DO;
        end
    end

    assign Sync    = active && (curOp == IO_IF);
    assign nRD     = !(active && (curOp == IO_RD || curOp == IO_IF));
    assign nWR     = !(active && (curOp == IO_WR));
    assign nCE_RAM = !(active && (rgn == RGN_RAM));
    assign nCE_ROM = !(active && (rgn == RGN_ROM));
    assign nCE_IO  = !(active && (rgn == RGN_IO));
    assign DI      = XDI;

endmodule

// File: tb/tb_m65c02_bus_ctrl.sv
// Self-checking bench for m65c02_bus_ctrl: directed vector table, hand-written
// wait/reset sequences and randomized traffic against a cycle-count reference model.
module tb_m65c02_bus_ctrl;

    localparam int unsigned WRAM = 0;
    localparam int unsigned WROM = 1;
    localparam int unsigned WIO  = 3;
    localparam logic [7:0]  IOPG = 8'hFE;

    typedef struct packed {
        logic        rdy;
        logic        sync;
        logic [15:0] xa;
        logic [7:0]  xdo;
        logic [7:0]  di;
        logic        nrd;
        logic        nwr;
        logic        nceRam;
        logic        nceRom;
        logic        nceIo;
    } outs_t;

    typedef struct {
        string       name;
        logic        rst;
        logic [15:0] ao;
        logic [1:0]  op;
        logic [7:0]  dout;
        logic        xw;
        logic [7:0]  xdi;
        outs_t       exp;
    } vec_t;

    logic        Clk;
    logic        Rst;
    logic [15:0] AO;
    logic [1:0]  IO_Op;
    logic [7:0]  DO;
    logic [7:0]  DI;
    logic        Rdy;
    logic        Sync;
    logic [15:0] XA;
    logic [7:0]  XDO;
    logic [7:0]  XDI;
    logic        nRD;
    logic        nWR;
    logic        nCE_RAM;
    logic        nCE_ROM;
    logic        nCE_IO;
    logic        XWait;

    int checks;
    int errors;
    vec_t vecs[$];

    // Reference model state: a cycle in progress plus the clocks it has used so far.
    bit          mBusy;
    int          mK;
    logic [15:0] mA;
    logic [7:0]  mD;
    logic [1:0]  mOp;

    m65c02_bus_ctrl #(
        .pWait_RAM (WRAM),
        .pWait_ROM (WROM),
        .pWait_IO  (WIO),
        .pIO_Page  (IOPG)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .AO      (AO),
        .IO_Op   (IO_Op),
        .DO      (DO),
        .DI      (DI),
        .Rdy     (Rdy),
        .Sync    (Sync),
        .XA      (XA),
        .XDO     (XDO),
        .XDI     (XDI),
        .nRD     (nRD),
        .nWR     (nWR),
        .nCE_RAM (nCE_RAM),
        .nCE_ROM (nCE_ROM),
        .nCE_IO  (nCE_IO),
        .XWait   (XWait)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic outs_t mk(input logic rdy, input logic sync, input logic [15:0] xa,
                                 input logic [7:0] xdo, input logic [7:0] di,
                                 input logic nrd, input logic nwr,
                                 input logic nram, input logic nrom, input logic nio);
        outs_t o;
        o.rdy = rdy; o.sync = sync; o.xa = xa; o.xdo = xdo; o.di = di;
        o.nrd = nrd; o.nwr = nwr; o.nceRam = nram; o.nceRom = nrom; o.nceIo = nio;
        return o;
    endfunction

    function automatic string fmtOut(input outs_t o);
        return $sformatf("rdy=%b sync=%b xa=%h xdo=%h di=%h nRD=%b nWR=%b nCE(ram,rom,io)=%b%b%b",
                         o.rdy, o.sync, o.xa, o.xdo, o.di, o.nrd, o.nwr, o.nceRam, o.nceRom, o.nceIo);
    endfunction

    function automatic int waitOf(input logic [15:0] a);
        if (a[15:8] == IOPG) return int'(WIO);
        if (a[15:12] == 4'hF) return int'(WROM);
        return int'(WRAM);
    endfunction

    task automatic addVec(input string name, input logic rst, input logic [15:0] ao,
                          input logic [1:0] op, input logic [7:0] dout, input logic xw,
                          input logic [7:0] xdi, input outs_t exp);
        vec_t v;
        v.name = name; v.rst = rst; v.ao = ao; v.op = op; v.dout = dout;
        v.xw = xw; v.xdi = xdi; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Drive one clock's inputs just after the active edge, then move to the sampling edge.
    task automatic applyStimulus(input logic rst, input logic [15:0] ao, input logic [1:0] op,
                                 input logic [7:0] dout, input logic xw, input logic [7:0] xdi);
        @(posedge Clk);
        #1;
        Rst   = rst;
        AO    = ao;
        IO_Op = op;
        DO    = dout;
        XWait = xw;
        XDI   = xdi;
        @(negedge Clk);
    endtask

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        act = mk(Rdy, Sync, XA, XDO, DI, nRD, nWR, nCE_RAM, nCE_ROM, nCE_IO);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %s, expected %s", name, fmtOut(act), fmtOut(exp));
        end
    endtask

    // Spec-level model: a cycle may end on its k-th clock (0-based) once k >= W and XWait is low.
    task automatic modelStep(input logic rst, input logic [15:0] ao, input logic [1:0] op,
                             input logic [7:0] dout, input logic xw, input logic [7:0] xdi,
                             output outs_t e);
        logic [15:0] a;
        logic [7:0]  d;
        logic [1:0]  o;
        bit act, done;
        e = mk(1'b0, 1'b0, ao, dout, xdi, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        if (rst) begin
            mBusy = 1'b0;
            mK    = 0;
            return;
        end
        if (mBusy) begin
            a = mA; d = mD; o = mOp;
        end else begin
            a = ao; d = dout; o = op; mK = 0;
        end
        act  = (o != 2'b00);
        done = !act || (mK >= waitOf(a) && !xw);
        e.rdy    = done;
        e.xa     = a;
        e.xdo    = d;
        e.sync   = act && (o == 2'b11);
        e.nrd    = !(act && (o == 2'b10 || o == 2'b11));
        e.nwr    = !(act && (o == 2'b01));
        e.nceIo  = !(act && a[15:8] == IOPG);
        e.nceRom = !(act && a[15:8] != IOPG && a[15:12] == 4'hF);
        e.nceRam = !(act && a[15:8] != IOPG && a[15:12] != 4'hF);
        if (act && !done) begin
            mBusy = 1'b1;
            mA = a; mD = d; mOp = o;
            mK++;
        end else begin
            mBusy = 1'b0;
        end
    endtask

    initial begin
        outs_t e;
        logic [15:0] ra;
        logic [1:0]  rop;
        logic [7:0]  rdo, rxdi;
        logic        rxw, rrst;

        checks = 0;
        errors = 0;
        Rst = 1'b1; AO = 16'h0000; IO_Op = 2'b00; DO = 8'h00; XWait = 1'b0; XDI = 8'h00;

        //      name      rst  AO        op     DO     XW    XDI         rdy   sync  XA        XDO    DI     nRD   nWR   ram   rom   io
        addVec("reset",   1'b1, 16'h1234, 2'b10, 8'h11, 1'b0, 8'h3C, mk(1'b0, 1'b0, 16'h1234, 8'h11, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        addVec("idleOp",  1'b0, 16'h0300, 2'b00, 8'h22, 1'b0, 8'h3C, mk(1'b1, 1'b0, 16'h0300, 8'h22, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        addVec("ramRd",   1'b0, 16'h0200, 2'b10, 8'h00, 1'b0, 8'h5A, mk(1'b1, 1'b0, 16'h0200, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
        addVec("romIf1",  1'b0, 16'hFFFC, 2'b11, 8'h00, 1'b0, 8'h3C, mk(1'b0, 1'b1, 16'hFFFC, 8'h00, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
        addVec("romIf2",  1'b0, 16'h1234, 2'b01, 8'h77, 1'b0, 8'h3C, mk(1'b1, 1'b1, 16'hFFFC, 8'h00, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
        addVec("ioWr1",   1'b0, 16'hFE10, 2'b01, 8'hA5, 1'b0, 8'h3C, mk(1'b0, 1'b0, 16'hFE10, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
        addVec("ioWr2",   1'b0, 16'h0000, 2'b10, 8'h00, 1'b0, 8'h3C, mk(1'b0, 1'b0, 16'hFE10, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
        addVec("ioWr3",   1'b0, 16'h0000, 2'b11, 8'h00, 1'b0, 8'h3C, mk(1'b0, 1'b0, 16'hFE10, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
        addVec("ioWr4",   1'b0, 16'h0000, 2'b00, 8'h00, 1'b0, 8'h3C, mk(1'b1, 1'b0, 16'hFE10, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
        addVec("b2bWr",   1'b0, 16'h0040, 2'b01, 8'h99, 1'b0, 8'h3C, mk(1'b1, 1'b0, 16'h0040, 8'h99, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        addVec("b2bRd",   1'b0, 16'h0041, 2'b10, 8'h66, 1'b0, 8'h3C, mk(1'b1, 1'b0, 16'h0041, 8'h66, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
        addVec("ramXw1",  1'b0, 16'h0100, 2'b10, 8'h44, 1'b1, 8'h3C, mk(1'b0, 1'b0, 16'h0100, 8'h44, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
        addVec("ramXw2",  1'b0, 16'h0555, 2'b01, 8'h88, 1'b0, 8'h3C, mk(1'b1, 1'b0, 16'h0100, 8'h44, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
        addVec("idleXw",  1'b0, 16'hFFFF, 2'b00, 8'h12, 1'b1, 8'h3C, mk(1'b1, 1'b0, 16'hFFFF, 8'h12, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].ao, vecs[i].op, vecs[i].dout, vecs[i].xw, vecs[i].xdi);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // IO read stretched by XWait for two clocks after the internal count runs out.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, (i == 0) ? 16'hFE20 : 16'h0010, (i == 0) ? 2'b10 : 2'b01,
                          (i == 0) ? 8'h5B : 8'h00, (i == 3 || i == 4), 8'hC3);
            checkOutput($sformatf("ioRdXw%0d", i),
                        mk(i == 5, 1'b0, 16'hFE20, 8'h5B, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        end

        // Reset in the second clock of an IO cycle, then a zero-wait RAM read.
        applyStimulus(1'b0, 16'hFE30, 2'b10, 8'h00, 1'b0, 8'h3C);
        checkOutput("rstMid0", mk(1'b0, 1'b0, 16'hFE30, 8'h00, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        applyStimulus(1'b1, 16'h0000, 2'b10, 8'h00, 1'b0, 8'h3C);
        checkOutput("rstMid1", mk(1'b0, 1'b0, 16'h0000, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        applyStimulus(1'b0, 16'h0200, 2'b10, 8'h00, 1'b0, 8'h3C);
        checkOutput("rstMid2", mk(1'b1, 1'b0, 16'h0200, 8'h00, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));

        // Randomized traffic; the DUT is idle here so the model starts idle too.
        mBusy = 1'b0;
        mK    = 0;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = {IOPG, 8'($urandom())};
                1:       ra = {4'hF, 12'($urandom())};
                default: ra = 16'($urandom());
            endcase
            rop  = 2'($urandom_range(0, 3));
            rdo  = 8'($urandom());
            rxdi = 8'($urandom());
            rxw  = ($urandom_range(0, 3) == 0);
            rrst = ($urandom_range(0, 49) == 0);
            modelStep(rrst, ra, rop, rdo, rxw, rxdi, e);
            applyStimulus(rrst, ra, rop, rdo, rxw, rxdi);
            checkOutput($sformatf("rand%0d", i), e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m65c02_bus_ctrl.md
Name: m65c02_bus_ctrl

Overview:
Memory bus cycle controller that sits directly downstream of the core's address generator. It consumes the generated address output and the microcode I/O operation, and decodes the target region (RAM/ROM/IO). It drives external chip-enable and read/write strobes, inserts per-region and externally requested wait states, and returns Rdy to the core. Rdy gates every core register update, including MAR, PC and stack pointer.

Parameters:
pWait_RAM, 0, wait states inserted for RAM accesses (0-7)
pWait_ROM, 1, wait states for ROM accesses (0-7)
pWait_IO, 3, wait states for IO accesses (0-7)
pIO_Page, 8'hFE, AO[15:8] value selecting IO region

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous active-high reset
AO  in  16  address from address generator
IO_Op  in  2  00 none, 01 write, 10 read, 11 fetch
DO  in  8  core write data
DI  out  8  read data to core
Rdy  out  1  cycle complete / core advance enable
Sync  out  1  opcode-fetch cycle indicator
XA  out  16  external address
XDO  out  8  external write data
XDI  in  8  external read data
nRD  out  1  read strobe, active low
nWR  out  1  write strobe, active low
nCE_RAM  out  1  RAM select, active low
nCE_ROM  out  1  ROM select, active low
nCE_IO  out  1  IO select, active low
XWait  in  1  external wait request, active high

Behaviour:
- Region decode: IO if A[15:8]==pIO_Page; else ROM if A[15:12]==4'hF; else RAM. Exactly one nCE is low during an active cycle.
- Wait count W comes from the decoded region.
- States: IDLE, WS (internal wait count), XW (external stretch).
- Cycle start: in IDLE with IO_Op!=00. Cycle length is W+1 clocks minimum. The last clock is the one where count==0 and XWait==0.
- Address/data source:
  - First clock: XA=AO, XDO=DO.
  - On the first clock's edge (if not complete): latch A<=AO, D<=DO, Op<=IO_Op, cnt<=W-1.
  - Subsequent clocks: XA=A, XDO=D.
- IDLE, IO_Op!=00:
  - W==0 and XWait==0: Rdy=1, stay IDLE (zero-wait cycle).
  - W==0 and XWait==1: Rdy=0, go XW.
  - W>0: Rdy=0, go WS.
- WS:
  - cnt!=0: cnt--, Rdy=0.
  - cnt==0 and XWait==0: Rdy=1, go IDLE.
  - cnt==0 and XWait==1: go XW.
- XW: Rdy=XWait==0. When Rdy=1, go IDLE.
- IDLE, IO_Op==00: Rdy=1 (internal cycle), all strobes high, XA=AO.
- Strobes (active clocks of a cycle): nRD low for read/fetch, nWR low for write. They never overlap and are high in IDLE with no op.
- Sync=1 for every clock of a fetch cycle.
- DI=XDI combinationally. The core samples DI only when Rdy=1.
- Back-to-back cycles: a new IO_Op in the clock after Rdy=1 starts immediately; no idle clock is required.
- IO_Op/AO changes while Rdy=0 are ignored; latched values are used.
- Reset:
  - While Rst=1: Rdy=0, Sync=0, all nCE/nRD/nWR=1, XA=AO, XDO=DO.
  - Next edge: state=IDLE, cnt=0, A=0, D=0, Op=00.
  - Rst asserted mid-cycle aborts the cycle; strobes go high in the same clock.
- Wait count is 3 bits. A parameter value >7 is a configuration error; assert at elaboration.

Decomposition:
- Shared package m65c02_pkg: IO_Op encodings (IO_NONE, IO_WR, IO_RD, IO_IF), region enum (RGN_RAM/ROM/IO), bus-state enum.
- Sub-module m65c02_rgn_decode (combinational address→region + wait count) is natural. The FSM, latches and strobes stay in the top.

Test Plan:
- RAM read at AO=16'h0200, IO_Op=10, XWait=0 → Rdy=1 same clock; nCE_RAM=0, nRD=0, XA=0200, DI=XDI.
- ROM fetch at 16'hFFFC → first clock Rdy=0 and Sync=1; second clock Rdy=1 and nCE_ROM=0; XA holds FFFC even if AO changes in the second clock.
- IO write AO=16'hFE10, DO=8'hA5 → nWR=0 for 4 clocks, Rdy=1 only in clock 4, XDO=A5 throughout, nCE_IO=0.
- IO read with XWait held high 2 extra clocks after count expires → Rdy=0 for 5 clocks, Rdy=1 on 6th; nRD low all 6.
- Back-to-back RAM write then RAM read (0 waits) → two consecutive Rdy=1 clocks; nWR then nRD with no overlap.
- Rst asserted in 2nd clock of IO cycle → strobes high that clock, Rdy=0; after release, state=IDLE and a new RAM read completes in 1 clock.
